// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
package mem_arb_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;
    localparam int N_REQ      = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
endpackage

// File: rtl/mem_rr_arbiter_if.sv
// Requester handshakes plus memory pins, bundled for the arbiter port.
interface mem_rr_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req0, wr0, ack0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0, rdata0;
    logic              req1, wr1, ack1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1, rdata1;
    logic              mem_en, mem_wr;
    logic [ADDR_W-1:0] mem_add;
    logic [DATA_W-1:0] mem_din, mem_dout;
    logic              busy, gnt_id;

    modport slave (
        input  req0, wr0, addr0, wdata0, req1, wr1, addr1, wdata1, mem_dout,
        output ack0, rdata0, ack1, rdata1, mem_en, mem_wr, mem_add, mem_din, busy, gnt_id
    );

    modport master (
        output req0, wr0, addr0, wdata0, req1, wr1, addr1, wdata1, mem_dout,
        input  ack0, rdata0, ack1, rdata1, mem_en, mem_wr, mem_add, mem_din, busy, gnt_id
    );
endinterface

// File: rtl/mem_rr_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the non-last requester wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);
    always_comb begin
        valid  = |req;
        winner = (&req) ? ~last : req[1];
    end
endmodule

// File: rtl/mem_rr_arbiter.sv
// Serializes two requesters onto a single-port synchronous memory, one
// transaction at a time, with round-robin grant on ties.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input logic             clk,
    input logic             rst,
    mem_rr_arbiter_if.slave bus
);
    state_t                        state_q, state_d;
    logic                          gnt_q, gnt_d, last_q, last_d;
    logic                          mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]             mem_add_q, mem_add_d;
    logic [DATA_W-1:0]             mem_din_q, mem_din_d;
    logic [N_REQ-1:0]              ack_q, ack_d;
    logic [N_REQ-1:0][DATA_W-1:0]  rdata_q, rdata_d;
    logic                          pick_valid, pick_win;

    rr_pick2 u_pick (
        .req    ({bus.req1, bus.req0}),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_win)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        mem_en_d  = mem_en_q;
        mem_wr_d  = mem_wr_q;
        mem_add_d = mem_add_q;
        mem_din_d = mem_din_q;
        ack_d     = '0;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: if (pick_valid) begin
                gnt_d     = pick_win;
                last_d    = pick_win;
                mem_en_d  = 1'b1;
                mem_wr_d  = pick_win ? bus.wr1    : bus.wr0;
                mem_add_d = pick_win ? bus.addr1  : bus.addr0;
                mem_din_d = pick_win ? bus.wdata1 : bus.wdata0;
                state_d   = ISSUE;
            end
            ISSUE: begin
                // mem_wr_q still holds the op kind here; address/data are left parked
                mem_en_d = 1'b0;
                mem_wr_d = 1'b0;
                if (mem_wr_q) begin
                    ack_d[gnt_q] = 1'b1;
                    state_d      = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                rdata_d[gnt_q] = bus.mem_dout;
                ack_d[gnt_q]   = 1'b1;
                state_d        = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            mem_en_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            mem_add_q <= '0;
            mem_din_q <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            mem_en_q  <= mem_en_d;
            mem_wr_q  <= mem_wr_d;
            mem_add_q <= mem_add_d;
            mem_din_q <= mem_din_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.mem_en  = mem_en_q;
    assign bus.mem_wr  = mem_wr_q;
    assign bus.mem_add = mem_add_q;
    assign bus.mem_din = mem_din_q;
    assign bus.ack0    = ack_q[0];
    assign bus.ack1    = ack_q[1];
    assign bus.rdata0  = rdata_q[0];
    assign bus.rdata1  = rdata_q[1];
    assign bus.busy    = (state_q != IDLE);
    assign bus.gnt_id  = gnt_q;
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with a 1024x8 registered-read memory model.
module tb_mem_rr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] mem [1024];

    always #5 clk = ~clk;

    mem_rr_arbiter_if #(.ADDR_W(10), .DATA_W(8)) bus ();
    mem_rr_arbiter #(.ADDR_W(10), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_wr) mem[bus.mem_add] <= bus.mem_din;
            else            bus.mem_dout     <= mem[bus.mem_add];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit id, input bit req, input bit wr, input logic [9:0] a,
                         input logic [7:0] d);
        if (id) begin
            bus.req1 = req; bus.wr1 = wr; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = req; bus.wr0 = wr; bus.addr0 = a; bus.wdata0 = d;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
    endtask

    // steps until ack of requester id; lat counts edges from the current cycle
    task automatic wait_ack(input string tag, input bit id, output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (((id ? bus.ack1 : bus.ack0) == 1'b0) && lat < 12);
        chk(tag, id ? bus.ack1 : bus.ack0, 1);
    endtask

    initial begin
        int lat;
        int n0, n1, nacks, id;
        bus.mem_dout = '0;
        do_reset();
        rst = 1'b1;
        #1;
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_wr", bus.mem_wr, 0);
        chk("rst_mem_add", bus.mem_add, 0);
        chk("rst_mem_din", bus.mem_din, 0);
        chk("rst_acks", {bus.ack1, bus.ack0}, 0);
        chk("rst_rdata", {bus.rdata1, bus.rdata0}, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_gnt", bus.gnt_id, 0);
        step();
        rst = 1'b0;

        // 1: single write, ack two cycles after sampling
        drive(0, 1, 1, 10'd32, 8'd43);
        step();
        chk("t1_en", bus.mem_en, 1);
        chk("t1_wr", bus.mem_wr, 1);
        chk("t1_add", bus.mem_add, 32);
        chk("t1_din", bus.mem_din, 43);
        chk("t1_busy", bus.busy, 1);
        chk("t1_ack_early", bus.ack0, 0);
        step();
        chk("t1_ack0", bus.ack0, 1);
        chk("t1_ack1", bus.ack1, 0);
        chk("t1_en_off", bus.mem_en, 0);
        chk("t1_wr_off", bus.mem_wr, 0);
        chk("t1_add_hold", bus.mem_add, 32);
        drive(0, 0, 0, 0, 0);
        step();
        chk("t1_ack_drop", bus.ack0, 0);
        chk("t1_idle", bus.busy, 0);

        // 2: read back, ack three cycles after sampling
        drive(0, 1, 0, 10'd32, 8'd0);
        step();
        chk("t2_en", bus.mem_en, 1);
        chk("t2_wr", bus.mem_wr, 0);
        chk("t2_add", bus.mem_add, 32);
        step();
        chk("t2_wait_en", bus.mem_en, 0);
        chk("t2_wait_ack", bus.ack0, 0);
        step();
        chk("t2_ack0", bus.ack0, 1);
        chk("t2_rdata0", bus.rdata0, 43);
        drive(0, 0, 0, 0, 0);
        step();
        step();
        chk("t2_rdata_hold", bus.rdata0, 43);
        chk("t2_ack_drop", bus.ack0, 0);

        // 3: simultaneous writes after reset, req0 first
        do_reset();
        drive(0, 1, 1, 10'd5, 8'hAA);
        drive(1, 1, 1, 10'd5, 8'h55);
        step();
        chk("t3_gnt_a", bus.gnt_id, 0);
        chk("t3_din_a", bus.mem_din, 8'hAA);
        step();
        chk("t3_ack0", bus.ack0, 1);
        drive(0, 0, 0, 0, 0);
        step();
        step();
        chk("t3_gnt_b", bus.gnt_id, 1);
        chk("t3_din_b", bus.mem_din, 8'h55);
        step();
        chk("t3_ack1", bus.ack1, 1);
        drive(1, 0, 0, 0, 0);
        step();
        drive(0, 1, 0, 10'd5, 8'd0);
        wait_ack("t3_rd_ack", 0, lat);
        chk("t3_rd_lat", lat, 3);
        chk("t3_rdata0", bus.rdata0, 8'h55);
        drive(0, 0, 0, 0, 0);
        step();

        // 4: both requesting continuously, strict alternation
        do_reset();
        n0 = 0; n1 = 0; nacks = 0;
        drive(0, 1, 1, 10'd100, 8'h10);
        drive(1, 1, 1, 10'd200, 8'h20);
        for (int cyc = 0; cyc < 100 && nacks < 8; cyc++) begin
            step();
            if (bus.ack0 | bus.ack1) begin
                id = int'(bus.ack1);
                chk("t4_order", id, nacks % 2);
                chk("t4_gnt", bus.gnt_id, id);
                chk("t4_one_ack", bus.ack0 & bus.ack1, 0);
                if (id == 1) n1++; else n0++;
                nacks++;
                if (nacks == 8) begin
                    drive(0, 0, 0, 0, 0);
                    drive(1, 0, 0, 0, 0);
                end else begin
                    drive(id[0], 1, 1, 10'(100 + nacks), 8'(nacks));
                end
            end
        end
        chk("t4_n0", n0, 4);
        chk("t4_n1", n1, 4);
        step();

        // 5: reset during the WAIT cycle of a req1 read drops it silently
        drive(1, 1, 0, 10'd32, 8'd0);
        step();
        chk("t5_gnt", bus.gnt_id, 1);
        step();
        rst = 1'b1;
        #1;
        chk("t5_busy", bus.busy, 0);
        chk("t5_gnt_rst", bus.gnt_id, 0);
        chk("t5_add_rst", bus.mem_add, 0);
        chk("t5_en_rst", bus.mem_en, 0);
        drive(1, 0, 0, 0, 0);
        step();
        chk("t5_no_ack", {bus.ack1, bus.ack0}, 0);
        rst = 1'b0;
        step();
        chk("t5_no_ack_late", {bus.ack1, bus.ack0}, 0);
        chk("t5_rdata1_rst", bus.rdata1, 0);
        drive(1, 1, 0, 10'd32, 8'd0);
        step();
        chk("t5_regnt", bus.gnt_id, 1);
        wait_ack("t5_ack1", 1, lat);
        chk("t5_lat", lat, 2);
        chk("t5_rdata1", bus.rdata1, 43);
        drive(1, 0, 0, 0, 0);
        step();

        // 6: top address, no wrap
        drive(0, 1, 1, 10'd1023, 8'hFF);
        step();
        chk("t6_wadd", bus.mem_add, 1023);
        wait_ack("t6_wack", 0, lat);
        chk("t6_wlat", lat, 1);
        drive(0, 0, 0, 0, 0);
        step();
        drive(1, 1, 0, 10'd1023, 8'd0);
        step();
        chk("t6_radd", bus.mem_add, 1023);
        wait_ack("t6_rack", 1, lat);
        chk("t6_rdata1", bus.rdata1, 8'hFF);
        drive(1, 0, 0, 0, 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
